// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 holds the accepted opcode and operands, S2 holds
// the registered results. Valid/ready on both sides, one operation per clock.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] readData0,
  input  logic [WIDTH-1:0] readData1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             taken,
  output logic             carry,
  output logic             illegal
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_EVENU = 4'd2,
    OP_EVENL = 4'd3,
    OP_GTE   = 4'd4,
    OP_LTZ   = 4'd5,
    OP_EZ    = 4'd6,
    OP_EQ    = 4'd7,
    OP_NE    = 4'd8,
    OP_AND   = 4'd9,
    OP_OR    = 4'd10,
    OP_XOR   = 4'd11,
    OP_SLT   = 4'd12
  } op_e;

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             accept;
  logic             s1_advance;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  logic [WIDTH-1:0] nx_result;
  logic             nx_taken;
  logic             nx_carry;
  logic             nx_illegal;

  // S1 may move into S2 whenever S2 is empty or is being drained this cycle.
  assign s1_advance = s1_valid && (!out_valid || out_ready);
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;

  // The extra top bit is the carry for add and the borrow (A<B) for sub.
  assign sum_ext  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_ext = {1'b0, s1_a} - {1'b0, s1_b};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    nx_result  = '0;
    nx_taken   = 1'b0;
    nx_carry   = 1'b0;
    nx_illegal = 1'b0;
    case (s1_op)
      OP_ADD:   begin nx_result = sum_ext[WIDTH-1:0];  nx_carry = sum_ext[WIDTH];  end
      OP_SUB:   begin nx_result = diff_ext[WIDTH-1:0]; nx_carry = diff_ext[WIDTH]; end
      OP_EVENU: nx_result[0] = ~^s1_a[WIDTH-1:WIDTH/2];
      OP_EVENL: nx_result[0] = ~^s1_a[WIDTH/2-1:0];
      OP_GTE:   nx_taken = (s1_a >= s1_b);
      OP_LTZ:   nx_taken = s1_a[WIDTH-1];
      OP_EZ:    nx_taken = (s1_a == '0);
      OP_EQ:    nx_taken = (s1_a == s1_b);
      OP_NE:    nx_taken = (s1_a != s1_b);
      OP_AND:   nx_result = s1_a & s1_b;
      OP_OR:    nx_result = s1_a | s1_b;
      OP_XOR:   nx_result = s1_a ^ s1_b;
      OP_SLT:   nx_taken = ($signed(s1_a) < $signed(s1_b));
      default:  nx_illegal = 1'b1;
    endcase
  end

  // NOTE: the S1 operand registers carry no reset; they are only observed
  // while s1_valid is set, and s1_valid itself is reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op <= operation;
      s1_a  <= readData0;
      s1_b  <= readData1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      taken     <= 1'b0;
      carry     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (accept)
        s1_valid <= 1'b1;
      else if (s1_advance)
        s1_valid <= 1'b0;

      // Results load only on advance, so they hold under backpressure.
      if (s1_advance) begin
        out_valid <= 1'b1;
        result    <= nx_result;
        taken     <= nx_taken;
        carry     <= nx_carry;
        illegal   <= nx_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: vector table through the 16-bit build, then
// streaming, backpressure, mid-stream reset and an 8-bit build.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  operation;
  logic [15:0] a, b, result;
  logic        taken, carry, illegal;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0]  operation8;
  logic [7:0]  a8, b8, result8;
  logic        taken8, carry8, illegal8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .readData0(a), .readData1(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .taken(taken), .carry(carry), .illegal(illegal)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .operation(operation8), .readData0(a8), .readData1(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .taken(taken8), .carry(carry8), .illegal(illegal8)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        tk;
    logic        cy;
    logic        il;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [15:0] va,
                         input logic [15:0] vb, input logic [15:0] res, input logic tk,
                         input logic cy, input logic il);
    vec_t v;
    v.name = name; v.op = op; v.a = va; v.b = vb;
    v.res = res; v.tk = tk; v.cy = cy; v.il = il;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name, input logic [15:0] res, input logic tk,
                           input logic cy, input logic il);
    check({name, ".valid"}, 32'(out_valid), 32'd1);
    check({name, ".result"}, 32'(result), 32'(res));
    check({name, ".taken"}, 32'(taken), 32'(tk));
    check({name, ".carry"}, 32'(carry), 32'(cy));
    check({name, ".illegal"}, 32'(illegal), 32'(il));
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb);
    in_valid = 1'b1; operation = op; a = va; b = vb;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; operation = '0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; operation8 = '0; a8 = '0; b8 = '0;

    add_vec("add_wrap",   4'd0,  16'hFFFF, 16'h0002, 16'h0001, 0, 1, 0);
    add_vec("sub_borrow", 4'd1,  16'h0005, 16'h0007, 16'hFFFE, 0, 1, 0);
    add_vec("sub_plain",  4'd1,  16'h0007, 16'h0005, 16'h0002, 0, 0, 0);
    add_vec("evenu_2",    4'd2,  16'h0300, 16'hFFFF, 16'h0001, 0, 0, 0);
    add_vec("evenu_1",    4'd2,  16'h0100, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec("evenl_3",    4'd3,  16'h0007, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec("evenl_0",    4'd3,  16'hFF00, 16'h0000, 16'h0001, 0, 0, 0);
    add_vec("gte_lt",     4'd4,  16'h0001, 16'h0002, 16'h0000, 0, 0, 0);
    add_vec("ltz_neg",    4'd5,  16'h8000, 16'h0000, 16'h0000, 1, 0, 0);
    add_vec("ltz_pos",    4'd5,  16'h7FFF, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec("ez_zero",    4'd6,  16'h0000, 16'h1234, 16'h0000, 1, 0, 0);
    add_vec("ez_one",     4'd6,  16'h0001, 16'h0000, 16'h0000, 0, 0, 0);
    add_vec("eq_same",    4'd7,  16'h0003, 16'h0003, 16'h0000, 1, 0, 0);
    add_vec("ne_diff",    4'd8,  16'h0003, 16'h0004, 16'h0000, 1, 0, 0);
    add_vec("ne_same",    4'd8,  16'h0005, 16'h0005, 16'h0000, 0, 0, 0);
    add_vec("and",        4'd9,  16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0);
    add_vec("or",         4'd10, 16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0);
    add_vec("xor",        4'd11, 16'hFFFF, 16'h00FF, 16'hFF00, 0, 0, 0);
    add_vec("slt_neg",    4'd12, 16'h8000, 16'h0001, 16'h0000, 1, 0, 0);
    add_vec("slt_pos",    4'd12, 16'h0001, 16'h8000, 16'h0000, 0, 0, 0);
    add_vec("slt_m1",     4'd12, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0);
    add_vec("illegal14",  4'd14, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 1);
    add_vec("gte_after",  4'd4,  16'h0002, 16'h0002, 16'h0000, 1, 0, 0);
    add_vec("illegal13",  4'd13, 16'h1234, 16'h0001, 16'h0000, 0, 0, 1);
    add_vec("illegal15",  4'd15, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.flags", {29'd0, taken, carry, illegal}, 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);

    // Exact latency on the first vector: valid appears after the second edge
    drive(vecs[0].op, vecs[0].a, vecs[0].b);
    @(negedge clk); in_valid = 1'b0;
    check("lat.edge1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_out("lat.add", vecs[0].res, vecs[0].tk, vecs[0].cy, vecs[0].il);
    @(negedge clk);
    check("lat.drained", 32'(out_valid), 32'd0);

    // Table: one operation at a time with a bounded wait for the result
    for (int i = 0; i < vecs.size(); i++) begin
      int wait_cycles;
      check({vecs[i].name, ".in_ready"}, 32'(in_ready), 32'd1);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk); in_valid = 1'b0;
      wait_cycles = 0;
      while (!out_valid && wait_cycles < 10) begin
        @(negedge clk); wait_cycles++;
      end
      check_out(vecs[i].name, vecs[i].res, vecs[i].tk, vecs[i].cy, vecs[i].il);
      @(negedge clk);
    end

    // Back-to-back stream, one result per cycle
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        check($sformatf("stream.in_ready%0d", i), 32'(in_ready), 32'd1);
        case (i)
          0: drive(4'd1,  16'h0005, 16'h0007);
          1: drive(4'd7,  16'h0003, 16'h0003);
          2: drive(4'd12, 16'h8000, 16'h0001);
          3: drive(4'd2,  16'h0300, 16'h0000);
          default: drive(4'd3, 16'h0007, 16'h0000);
        endcase
      end else begin
        in_valid = 1'b0;
      end
      case (i)
        2: check_out("stream.sub",   16'hFFFE, 0, 1, 0);
        3: check_out("stream.eq",    16'h0000, 1, 0, 0);
        4: check_out("stream.slt",   16'h0000, 1, 0, 0);
        5: check_out("stream.evenu", 16'h0001, 0, 0, 0);
        6: check_out("stream.evenl", 16'h0000, 0, 0, 0);
        default: ;
      endcase
      @(negedge clk);
    end
    check("stream.idle", 32'(out_valid), 32'd0);

    // Backpressure: two ops fill the pipe, the third waits for the first transfer
    out_ready = 1'b0;
    check("bp.ready0", 32'(in_ready), 32'd1);
    drive(4'd0, 16'h0001, 16'h0002);
    @(negedge clk);
    check("bp.ready1", 32'(in_ready), 32'd1);
    drive(4'd11, 16'hF0F0, 16'h0FF0);
    @(negedge clk);
    drive(4'd10, 16'h0001, 16'h0100);
    check("bp.ready2", 32'(in_ready), 32'd0);
    check_out("bp.hold0", 16'h0003, 0, 0, 0);
    @(negedge clk);
    check("bp.ready3", 32'(in_ready), 32'd0);
    check_out("bp.hold1", 16'h0003, 0, 0, 0);
    out_ready = 1'b1;
    #1;
    check("bp.ready_on_xfer", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0;
    check_out("bp.second", 16'hFF00, 0, 0, 0);
    @(negedge clk);
    check_out("bp.third", 16'h0101, 0, 0, 0);
    @(negedge clk);
    check("bp.empty", 32'(out_valid), 32'd0);

    // Reset with two operations in flight
    drive(4'd0, 16'h1234, 16'h1111);
    @(negedge clk);
    drive(4'd9, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("rstmid.pre", 16'h2345, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid.valid", 32'(out_valid), 32'd0);
    check("rstmid.result", 32'(result), 32'd0);
    check("rstmid.flags", {29'd0, taken, carry, illegal}, 32'd0);
    check("rstmid.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rstmid.quiet%0d", i), 32'(out_valid), 32'd0);
    end

    // 8-bit build
    in_valid8 = 1'b1; operation8 = 4'd0; a8 = 8'hF0; b8 = 8'h20;
    @(negedge clk);
    operation8 = 4'd5; a8 = 8'h80; b8 = 8'h00;
    @(negedge clk);
    in_valid8 = 1'b0;
    check("w8.add.valid", 32'(out_valid8), 32'd1);
    check("w8.add.result", 32'(result8), 32'h10);
    check("w8.add.carry", 32'(carry8), 32'd1);
    check("w8.add.other", {30'd0, taken8, illegal8}, 32'd0);
    @(negedge clk);
    check("w8.ltz.valid", 32'(out_valid8), 32'd1);
    check("w8.ltz.taken", 32'(taken8), 32'd1);
    check("w8.ltz.other", {23'd0, result8, carry8}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
